rr_mux4_arbiter: RTL

- Round-robin arbiter and sequencer for a shared 4:1 multiplexed output path; four requesters share one output lane.
- Owns the mux select. It grants one requester at a time for a burst of up to BURST_LEN beats, then rotates priority.
- The selected lane drives a single valid/ready output; each consumed beat is acknowledged back to its requester.

---
 rtl/rr_arb_pkg.sv | 35 +++
 rtl/rr_mux4_arbiter_pick4.sv | 21 ++
 rtl/rr_mux4_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the four-requester round-robin arbiter.
// Holds the state encoding and the rotate-priority search used by the picker.
package rr_arb_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Search req starting at ptr, wrapping mod 4; returns {found, idx}.
    function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] req_v,
                                           input logic [1:0]         ptr_v);
        logic       found_v;
        logic [1:0] idx_v;
        logic [1:0] cand_v;
        found_v = 1'b0;
        idx_v   = 2'd0;
        cand_v  = 2'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_v = ptr_v + 2'(i);
            if (!found_v && req_v[cand_v]) begin
                found_v = 1'b1;
                idx_v   = cand_v;
            end
        end
        return {found_v, idx_v};
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot4(input logic [1:0] idx_v);
        return 4'b0001 << idx_v;
    endfunction

endpackage

// File: rtl/rr_mux4_arbiter_pick4.sv
// Combinational rotate-priority encoder: the first set request at or after ptr wins.
module rr_mux4_arbiter_pick4
    import rr_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic               found,
    output logic [1:0]         idx
);

    logic [2:0] pick_s;

    // Rotate-priority search over the four request bits
    always_comb begin
        pick_s = 3'b000;
        pick_s = rr_pick(req, ptr);
        found  = pick_s[2];
        idx    = pick_s[1:0];
    end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter owning the select of a shared 4:1 data lane.
// Grants one requester for up to BURST_LEN accepted beats, then rotates priority.
module rr_mux4_arbiter
    import rr_arb_pkg::*;
#(
    parameter int DATA_W    = 1,
    parameter int BURST_LEN = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   data_in,
    input  logic                        out_ready,
    output logic [1:0]                  sel,
    output logic [NUM_REQ-1:0]          grant,
    output logic [NUM_REQ-1:0]          ack,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic                        busy
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    arb_state_t          state_r;
    logic [1:0]          sel_r;
    logic [NUM_REQ-1:0]  grant_r;
    logic                busy_r;
    logic [1:0]          ptr_r;
    logic [CNT_W-1:0]    beat_cnt_r;

    logic [1:0]          pick_ptr_s;
    logic                pick_found_s;
    logic [1:0]          pick_idx_s;
    logic                valid_s;
    logic                accept_s;
    logic                release_s;

    // In GRANT the search is only consumed at release, where priority starts after sel
    always_comb begin
        pick_ptr_s = ptr_r;
        if (state_r == ST_GRANT) begin
            pick_ptr_s = sel_r + 2'd1;
        end else begin
            pick_ptr_s = ptr_r;
        end
    end

    rr_mux4_arbiter_pick4 u_pick (
        .req   (req),
        .ptr   (pick_ptr_s),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    // Handshake, release decision and output lane steering
    always_comb begin
        valid_s   = 1'b0;
        accept_s  = 1'b0;
        release_s = 1'b0;
        if (state_r == ST_GRANT) begin
            valid_s   = req[sel_r];
            accept_s  = req[sel_r] & out_ready;
            release_s = (accept_s && (beat_cnt_r == LAST_BEAT)) || !req[sel_r];
        end else begin
            valid_s   = 1'b0;
            accept_s  = 1'b0;
            release_s = 1'b0;
        end
        out_valid = valid_s;
        out_data  = data_in[sel_r*DATA_W +: DATA_W];
        if (accept_s) begin
            ack = grant_r;
        end else begin
            ack = {NUM_REQ{1'b0}};
        end
    end

    // Arbitration FSM with burst counter; release reloads in the same edge so back-to-back grants have no bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            sel_r      <= 2'd0;
            grant_r    <= {NUM_REQ{1'b0}};
            busy_r     <= 1'b0;
            ptr_r      <= 2'd0;
            beat_cnt_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_found_s) begin
                        state_r    <= ST_GRANT;
                        sel_r      <= pick_idx_s;
                        grant_r    <= onehot4(pick_idx_s);
                        busy_r     <= 1'b1;
                        beat_cnt_r <= {CNT_W{1'b0}};
                    end else begin
                        state_r    <= ST_IDLE;
                        grant_r    <= {NUM_REQ{1'b0}};
                        busy_r     <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (release_s) begin
                        ptr_r      <= pick_ptr_s;
                        beat_cnt_r <= {CNT_W{1'b0}};
                        if (pick_found_s) begin
                            state_r <= ST_GRANT;
                            sel_r   <= pick_idx_s;
                            grant_r <= onehot4(pick_idx_s);
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                            grant_r <= {NUM_REQ{1'b0}};
                            busy_r  <= 1'b0;
                        end
                    end else if (accept_s) begin
                        beat_cnt_r <= beat_cnt_r + CNT_W'(1);
                    end else begin
                        beat_cnt_r <= beat_cnt_r;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    grant_r    <= {NUM_REQ{1'b0}};
                    busy_r     <= 1'b0;
                    beat_cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign sel   = sel_r;
    assign grant = grant_r;
    assign busy  = busy_r;

endmodule
